idu_stage: RTL and testbench
============================

// Module: idu_stage
// PURPOSE
//  Registered, parametrised decode stage between the if_id pipe and id_ex.
//  Buffers fetched {inst, pc} pairs in a FIFO_DEPTH-entry queue. Decodes the queue head and reads the GPRs.
//  Detects load-use hazards and raises an illegal-instruction flag.
//  Presents results through a valid/ready output register. Replaces the purely combinational decoder.
// PARAMETERS
//  FIFO_DEPTH  2  instruction queue entries; power of two, >= 2
// PORTS
//  clk              in   1    core clock
//  rst_n            in   1    asynchronous active-low reset
//  inst_valid_i     in   1    fetch offers inst_i/inst_addr_i
//  inst_ready_o     out  1    queue not full; push on valid & ready
//  inst_i           in   32   instruction word
//  inst_addr_i      in   32   instruction pc
//  flush_i          in   1    redirect: discard queue and output register
//  ex_load_valid_i  in   1    EX holds a load whose data is not yet available
//  ex_load_rd_i     in   5    rd of that load
//  rs1_raddr_o      out  5    GPR read address for queue head (comb, 0 if unused)
//  rs2_raddr_o      out  5    GPR read address for queue head (comb, 0 if unused)
//  rs1_rdata_i      in   32   GPR data (gpr_reg is write-through)
//  rs2_rdata_i      in   32   GPR data
//  stall_o          out  1    head valid and blocked by hazard (comb)
//  dec_valid_o      out  1    output register holds a decoded instruction
//  dec_ready_i      in   1    id_ex accepts; transfer on valid & ready
//  inst_o, dec_pc_o, dec_imm_o, rs1_rdata_o, rs2_rdata_o  out  32  registered
//  dec_info_bus_o   out  `DECINFO_WIDTH  registered group/op bus
//  rd_waddr_o       out  5    registered; 0 when no rd write
//  rd_we_o          out  1    registered
//  illegal_o        out  1    registered; unrecognised encoding
// BEHAVIOUR
//  - Reset: queue empty, dec_valid_o=0, all registered outputs 0; inst_ready_o=1, stall_o=0.
//  - rst_n low mid-stream clears everything asynchronously.
//  - Queue: circular, wr/rd pointers plus count. Full -> inst_ready_o=0.
//    A simultaneous push and pop when not full is legal; count is unchanged. No bypass path.
//  - Latency: an instruction pushed at edge T is valid on dec_valid_o after edge T+1 at the earliest.
//  - Advance: head loads the output register when head valid & ~hazard & (~dec_valid_o | dec_ready_i).
//    If id_ex takes the output and no head advances, dec_valid_o goes 0.
//    dec_valid_o holds with stable data while dec_ready_i=0.
//  - Hazard: head uses rs1 (rs2) with nonzero address matching either of:
//    (a) ex_load_rd_i while ex_load_valid_i is high;
//    (b) rd_waddr_o of a load held valid in the output register.
//    On hazard, stall_o=1 and the head stays in place.
//  - Flush: flush_i empties the queue and clears dec_valid_o at the next edge.
//    A push or advance in the same cycle is discarded; flush wins.
//  - Decode: same field/immediate rules and DECINFO groups as existing (ALU/BJP/MULDIV/CSR/MEM/SYS).
//    Any encoding outside the supported set gives illegal_o=1, dec_info_bus_o=0, rd_we_o=0, rd_waddr_o=0.
//    Such an instruction still issues so the trap unit can act.
//  - Ordering: strict program order; no drop or duplicate except on flush.
// CONFIGURATION
//  IDU_RVM_EN defined: mul/mulh/mulhsu/mulhu/div/divu/rem/remu decode to the MULDIV group with rd write.
//  IDU_RVM_EN undefined: those encodings are illegal (illegal_o=1, no rd write, no rs reads required).
// STRUCTURE
//  - defines.v holds the shared constants: DECINFO_* widths, group codes, bit indices, INST_* constants.
//  - Sub-module idu_dec: combinational single-instruction decoder. It outputs info bus, imm,
//    rs1/rs2/rd addresses with use flags, is_load and illegal. It honours IDU_RVM_EN.
//  - idu_stage contains the queue, hazard compare, handshake and output register.
// TESTING
//  1. addi x1,x0,5 (0x00500093) at pc 0x80000000, dec_ready_i=1
//     -> dec_valid_o two edges later; ALU ADD and OP2IMM set, dec_imm_o=5, rd_waddr_o=1, rd_we_o=1.
//  2. dec_ready_i=0, push continuously
//     -> 1 into output register plus FIFO_DEPTH queued, then inst_ready_o=0.
//     -> Release ready: instructions emerge in push order, one per cycle.
//  3. lw x5,0(x2) (0x00012283) then add x6,x5,x1 (0x00128333)
//     -> stall_o=1 while lw is in the output register and while ex_load_valid_i=1 with ex_load_rd_i=5.
//     -> add issues the cycle after both clear.
//  4. flush_i=1 together with a push while 2 entries are queued
//     -> next edge: queue empty, dec_valid_o=0, pushed instruction absent.
//  5. mul x3,x1,x2 (0x022081b3)
//     -> with IDU_RVM_EN: MULDIV MUL bit set, rd_waddr_o=3.
//     -> without IDU_RVM_EN: illegal_o=1, rd_we_o=0. Also 0xFFFFFFFF -> illegal_o=1 in both builds.
//  6. Assert rst_n=0 mid-burst between edges
//     -> dec_valid_o=0 and inst_ready_o=1 immediately; first push after release decodes normally.

Source files
------------

// File: rtl/idu_stage_pkg.sv
// Shared decode constants for the idu_stage slice: info-bus layout,
// group codes, op-bit indices, opcode constants and the decoder result record.
// Optional feature macro used by the slice: IDU_RVM_EN (M-extension decode).
package idu_stage_pkg;

    // Info bus layout: group code in the low bits, one-hot op flags above it
    localparam int DECINFO_GRP_WIDTH = 3;
    localparam int DECINFO_WIDTH     = 16;

    typedef enum logic [2:0] {
        GRP_NONE   = 3'd0,
        GRP_ALU    = 3'd1,
        GRP_BJP    = 3'd2,
        GRP_MULDIV = 3'd3,
        GRP_CSR    = 3'd4,
        GRP_MEM    = 3'd5,
        GRP_SYS    = 3'd6
    } dec_group_e;

    // ALU group op bits
    localparam int ALU_ADD    = 3;
    localparam int ALU_SUB    = 4;
    localparam int ALU_XOR    = 5;
    localparam int ALU_OR     = 6;
    localparam int ALU_AND    = 7;
    localparam int ALU_SLL    = 8;
    localparam int ALU_SRL    = 9;
    localparam int ALU_SRA    = 10;
    localparam int ALU_SLT    = 11;
    localparam int ALU_SLTU   = 12;
    localparam int ALU_LUI    = 13;
    localparam int ALU_AUIPC  = 14;
    localparam int ALU_OP2IMM = 15;

    // Branch/jump group op bits
    localparam int BJP_JAL  = 3;
    localparam int BJP_JALR = 4;
    localparam int BJP_BEQ  = 5;
    localparam int BJP_BNE  = 6;
    localparam int BJP_BLT  = 7;
    localparam int BJP_BGE  = 8;
    localparam int BJP_BLTU = 9;
    localparam int BJP_BGEU = 10;

    // Multiply/divide group op bits, ordered to match funct3
    localparam int MD_MUL    = 3;
    localparam int MD_MULH   = 4;
    localparam int MD_MULHSU = 5;
    localparam int MD_MULHU  = 6;
    localparam int MD_DIV    = 7;
    localparam int MD_DIVU   = 8;
    localparam int MD_REM    = 9;
    localparam int MD_REMU   = 10;

    // CSR group op bits; RS1IMM marks the zimm forms
    localparam int CSR_CSRRW  = 3;
    localparam int CSR_CSRRS  = 4;
    localparam int CSR_CSRRC  = 5;
    localparam int CSR_RS1IMM = 6;

    // Memory group op bits; size is funct3[1:0], unsigned is funct3[2]
    localparam int MEM_LOAD     = 3;
    localparam int MEM_STORE    = 4;
    localparam int MEM_SIZE_LSB = 5;
    localparam int MEM_UNSIGNED = 7;

    // System group op bits
    localparam int SYS_ECALL  = 3;
    localparam int SYS_EBREAK = 4;
    localparam int SYS_MRET   = 5;
    localparam int SYS_WFI    = 6;
    localparam int SYS_FENCE  = 7;
    localparam int SYS_FENCEI = 8;

    // Major opcodes
    localparam logic [6:0] INST_OP_LUI    = 7'b0110111;
    localparam logic [6:0] INST_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] INST_OP_JAL    = 7'b1101111;
    localparam logic [6:0] INST_OP_JALR   = 7'b1100111;
    localparam logic [6:0] INST_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] INST_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] INST_OP_STORE  = 7'b0100011;
    localparam logic [6:0] INST_OP_IMM    = 7'b0010011;
    localparam logic [6:0] INST_OP_OP     = 7'b0110011;
    localparam logic [6:0] INST_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] INST_OP_SYSTEM = 7'b1110011;

    // Fixed system encodings
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] INST_WFI    = 32'h1050_0073;

    // Everything the stage needs to know about one decoded instruction
    typedef struct packed {
        logic [DECINFO_WIDTH-1:0] info;
        logic [31:0]              imm;
        logic [4:0]               rs1_addr;
        logic [4:0]               rs2_addr;
        logic [4:0]               rd_addr;
        logic                     use_rs1;
        logic                     use_rs2;
        logic                     rd_we;
        logic                     is_load;
        logic                     illegal;
    } dec_result_t;

    // Info bus with only the group code filled in
    function automatic logic [DECINFO_WIDTH-1:0] grp_info(input dec_group_e grp);
        logic [DECINFO_WIDTH-1:0] r;
        r = '0;
        r[DECINFO_GRP_WIDTH-1:0] = grp;
        return r;
    endfunction

endpackage

// File: rtl/idu_stage_dec.sv
// Combinational single-instruction RV32I decoder (plus M extension when
// IDU_RVM_EN is defined). Unsupported encodings come out as illegal with
// an empty info bus, no register reads and no rd write.
module idu_dec
    import idu_stage_pkg::*;
(
    input  logic [31:0] inst,
    output dec_result_t dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_csr;
    logic [31:0] imm_shamt;

    assign opcode    = inst[6:0];
    assign rd        = inst[11:7];
    assign funct3    = inst[14:12];
    assign rs1       = inst[19:15];
    assign rs2       = inst[24:20];
    assign funct7    = inst[31:25];
    assign imm_i     = {{20{inst[31]}}, inst[31:20]};
    assign imm_s     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u     = {inst[31:12], 12'd0};
    assign imm_j     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_csr   = {20'd0, inst[31:20]};
    assign imm_shamt = {27'd0, inst[24:20]};

    logic                     legal;
    logic                     use_rs1;
    logic                     use_rs2;
    logic                     has_rd;
    logic                     is_load;
    logic [DECINFO_WIDTH-1:0] info;
    logic [31:0]              imm;

    // Classify the encoding and collect raw decode fields before legality masking
    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        has_rd  = 1'b0;
        is_load = 1'b0;
        info    = '0;
        imm     = '0;
        case (opcode)
            INST_OP_LUI: begin
                legal  = 1'b1;
                has_rd = 1'b1;
                imm    = imm_u;
                info   = grp_info(GRP_ALU);
                info[ALU_LUI] = 1'b1;
            end
            INST_OP_AUIPC: begin
                legal  = 1'b1;
                has_rd = 1'b1;
                imm    = imm_u;
                info   = grp_info(GRP_ALU);
                info[ALU_AUIPC] = 1'b1;
            end
            INST_OP_JAL: begin
                legal  = 1'b1;
                has_rd = 1'b1;
                imm    = imm_j;
                info   = grp_info(GRP_BJP);
                info[BJP_JAL] = 1'b1;
            end
            INST_OP_JALR: begin
                legal   = (funct3 == 3'b000);
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                imm     = imm_i;
                info    = grp_info(GRP_BJP);
                info[BJP_JALR] = 1'b1;
            end
            INST_OP_BRANCH: begin
                legal   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_b;
                info    = grp_info(GRP_BJP);
                case (funct3)
                    3'b000:  info[BJP_BEQ]  = 1'b1;
                    3'b001:  info[BJP_BNE]  = 1'b1;
                    3'b100:  info[BJP_BLT]  = 1'b1;
                    3'b101:  info[BJP_BGE]  = 1'b1;
                    3'b110:  info[BJP_BLTU] = 1'b1;
                    3'b111:  info[BJP_BGEU] = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            INST_OP_LOAD: begin
                legal   = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                is_load = 1'b1;
                imm     = imm_i;
                info    = grp_info(GRP_MEM);
                info[MEM_LOAD] = 1'b1;
                info[MEM_SIZE_LSB+1:MEM_SIZE_LSB] = funct3[1:0];
                info[MEM_UNSIGNED] = funct3[2];
            end
            INST_OP_STORE: begin
                legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_s;
                info    = grp_info(GRP_MEM);
                info[MEM_STORE] = 1'b1;
                info[MEM_SIZE_LSB+1:MEM_SIZE_LSB] = funct3[1:0];
            end
            INST_OP_IMM: begin
                legal   = 1'b1;
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                imm     = imm_i;
                info    = grp_info(GRP_ALU);
                info[ALU_OP2IMM] = 1'b1;
                case (funct3)
                    3'b000: info[ALU_ADD]  = 1'b1;
                    3'b010: info[ALU_SLT]  = 1'b1;
                    3'b011: info[ALU_SLTU] = 1'b1;
                    3'b100: info[ALU_XOR]  = 1'b1;
                    3'b110: info[ALU_OR]   = 1'b1;
                    3'b111: info[ALU_AND]  = 1'b1;
                    3'b001: begin
                        imm   = imm_shamt;
                        legal = (funct7 == 7'b0000000);
                        info[ALU_SLL] = 1'b1;
                    end
                    default: begin
                        imm = imm_shamt;
                        if (funct7 == 7'b0000000) begin
                            info[ALU_SRL] = 1'b1;
                        end else if (funct7 == 7'b0100000) begin
                            info[ALU_SRA] = 1'b1;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                endcase
            end
            INST_OP_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                has_rd  = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    info  = grp_info(GRP_ALU);
                    case (funct3)
                        3'b000:  info[ALU_ADD]  = 1'b1;
                        3'b001:  info[ALU_SLL]  = 1'b1;
                        3'b010:  info[ALU_SLT]  = 1'b1;
                        3'b011:  info[ALU_SLTU] = 1'b1;
                        3'b100:  info[ALU_XOR]  = 1'b1;
                        3'b101:  info[ALU_SRL]  = 1'b1;
                        3'b110:  info[ALU_OR]   = 1'b1;
                        default: info[ALU_AND]  = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal = 1'b1;
                    info  = grp_info(GRP_ALU);
                    info[ALU_SUB] = 1'b1;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    legal = 1'b1;
                    info  = grp_info(GRP_ALU);
                    info[ALU_SRA] = 1'b1;
                end
`ifdef IDU_RVM_EN
                else if (funct7 == 7'b0000001) begin
                    legal = 1'b1;
                    info  = grp_info(GRP_MULDIV);
                    info[MD_MUL + int'(funct3)] = 1'b1;
                end
`endif
            end
            INST_OP_FENCE: begin
                info = grp_info(GRP_SYS);
                if (funct3 == 3'b000) begin
                    legal = 1'b1;
                    info[SYS_FENCE] = 1'b1;
                end else if (funct3 == 3'b001) begin
                    legal = 1'b1;
                    info[SYS_FENCEI] = 1'b1;
                end
            end
            INST_OP_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    info  = grp_info(GRP_SYS);
                    legal = 1'b1;
                    if (inst == INST_ECALL) begin
                        info[SYS_ECALL] = 1'b1;
                    end else if (inst == INST_EBREAK) begin
                        info[SYS_EBREAK] = 1'b1;
                    end else if (inst == INST_MRET) begin
                        info[SYS_MRET] = 1'b1;
                    end else if (inst == INST_WFI) begin
                        info[SYS_WFI] = 1'b1;
                    end else begin
                        legal = 1'b0;
                    end
                end else if (funct3 != 3'b100) begin
                    legal   = 1'b1;
                    has_rd  = 1'b1;
                    use_rs1 = ~funct3[2];
                    imm     = imm_csr;
                    info    = grp_info(GRP_CSR);
                    info[CSR_RS1IMM] = funct3[2];
                    case (funct3[1:0])
                        2'b01:   info[CSR_CSRRW] = 1'b1;
                        2'b10:   info[CSR_CSRRS] = 1'b1;
                        default: info[CSR_CSRRC] = 1'b1;
                    endcase
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Mask everything for illegal encodings; rd writes to x0 are suppressed
    always_comb begin
        dec = '0;
        if (legal) begin
            dec.info     = info;
            dec.imm      = imm;
            dec.use_rs1  = use_rs1;
            dec.use_rs2  = use_rs2;
            dec.rs1_addr = use_rs1 ? rs1 : 5'd0;
            dec.rs2_addr = use_rs2 ? rs2 : 5'd0;
            dec.rd_we    = has_rd && (rd != 5'd0);
            dec.rd_addr  = (has_rd && (rd != 5'd0)) ? rd : 5'd0;
            dec.is_load  = is_load;
        end else begin
            dec.illegal  = 1'b1;
        end
    end

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: instruction queue, head decode, load-use hazard
// detection and a valid/ready output register towards id_ex.
// Optional feature macro: IDU_RVM_EN (passed through to the idu_dec decoder).
module idu_stage
    import idu_stage_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inst_valid_i,
    output logic                     inst_ready_o,
    input  logic [31:0]              inst_i,
    input  logic [31:0]              inst_addr_i,
    input  logic                     flush_i,
    input  logic                     ex_load_valid_i,
    input  logic [4:0]               ex_load_rd_i,
    output logic [4:0]               rs1_raddr_o,
    output logic [4:0]               rs2_raddr_o,
    input  logic [31:0]              rs1_rdata_i,
    input  logic [31:0]              rs2_rdata_i,
    output logic                     stall_o,
    output logic                     dec_valid_o,
    input  logic                     dec_ready_i,
    output logic [31:0]              inst_o,
    output logic [31:0]              dec_pc_o,
    output logic [31:0]              dec_imm_o,
    output logic [31:0]              rs1_rdata_o,
    output logic [31:0]              rs2_rdata_o,
    output logic [DECINFO_WIDTH-1:0] dec_info_bus_o,
    output logic [4:0]               rd_waddr_o,
    output logic                     rd_we_o,
    output logic                     illegal_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      q_inst [FIFO_DEPTH];
    logic [31:0]      q_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic        head_valid;
    logic [31:0] head_inst;
    logic [31:0] head_pc;
    dec_result_t head_dec;
    logic        hazard;
    logic        advance;
    logic        push;
    logic        pop;
    logic        out_is_load;

    assign head_valid   = (count != '0);
    assign head_inst    = q_inst[rd_ptr];
    assign head_pc      = q_pc[rd_ptr];
    assign inst_ready_o = (count != CNT_W'(FIFO_DEPTH));
    assign push         = inst_valid_i && inst_ready_o && !flush_i;
    assign advance      = head_valid && !hazard && (!dec_valid_o || dec_ready_i);
    assign pop          = advance && !flush_i;
    assign stall_o      = head_valid && hazard;
    assign rs1_raddr_o  = head_valid ? head_dec.rs1_addr : 5'd0;
    assign rs2_raddr_o  = head_valid ? head_dec.rs2_addr : 5'd0;

    idu_dec u_dec (
        .inst (head_inst),
        .dec  (head_dec)
    );

    // Head source registers against the load in EX and the load waiting in the output register
    always_comb begin
        logic hit1;
        logic hit2;
        hit1 = (ex_load_valid_i && (ex_load_rd_i == head_dec.rs1_addr))
            || (dec_valid_o && out_is_load && (rd_waddr_o == head_dec.rs1_addr));
        hit2 = (ex_load_valid_i && (ex_load_rd_i == head_dec.rs2_addr))
            || (dec_valid_o && out_is_load && (rd_waddr_o == head_dec.rs2_addr));
        hazard = (head_dec.use_rs1 && (head_dec.rs1_addr != 5'd0) && hit1)
              || (head_dec.use_rs2 && (head_dec.rs2_addr != 5'd0) && hit2);
    end

    // Queue storage; contents are only meaningful below count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= inst_i;
            q_pc[wr_ptr]   <= inst_addr_i;
        end
    end

    // Queue pointers and occupancy; flush drops every queued entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register: load on advance, empty when taken without refill, hold under back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_o    <= 1'b0;
            inst_o         <= '0;
            dec_pc_o       <= '0;
            dec_imm_o      <= '0;
            rs1_rdata_o    <= '0;
            rs2_rdata_o    <= '0;
            dec_info_bus_o <= '0;
            rd_waddr_o     <= '0;
            rd_we_o        <= 1'b0;
            illegal_o      <= 1'b0;
            out_is_load    <= 1'b0;
        end else if (flush_i) begin
            dec_valid_o    <= 1'b0;
        end else if (advance) begin
            dec_valid_o    <= 1'b1;
            inst_o         <= head_inst;
            dec_pc_o       <= head_pc;
            dec_imm_o      <= head_dec.imm;
            rs1_rdata_o    <= rs1_rdata_i;
            rs2_rdata_o    <= rs2_rdata_i;
            dec_info_bus_o <= head_dec.info;
            rd_waddr_o     <= head_dec.rd_addr;
            rd_we_o        <= head_dec.rd_we;
            illegal_o      <= head_dec.illegal;
            out_is_load    <= head_dec.is_load;
        end else if (dec_ready_i) begin
            dec_valid_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idu_stage.sv
// Directed, table-driven bench for idu_stage: a decode vector table plus
// hand-written back-pressure, hazard, flush and mid-stream reset sequences.
module tb_idu_stage;
    import idu_stage_pkg::*;

    localparam int DEPTH = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     inst_valid_i;
    logic                     inst_ready_o;
    logic [31:0]              inst_i;
    logic [31:0]              inst_addr_i;
    logic                     flush_i;
    logic                     ex_load_valid_i;
    logic [4:0]               ex_load_rd_i;
    logic [4:0]               rs1_raddr_o;
    logic [4:0]               rs2_raddr_o;
    logic [31:0]              rs1_rdata_i;
    logic [31:0]              rs2_rdata_i;
    logic                     stall_o;
    logic                     dec_valid_o;
    logic                     dec_ready_i;
    logic [31:0]              inst_o;
    logic [31:0]              dec_pc_o;
    logic [31:0]              dec_imm_o;
    logic [31:0]              rs1_rdata_o;
    logic [31:0]              rs2_rdata_o;
    logic [DECINFO_WIDTH-1:0] dec_info_bus_o;
    logic [4:0]               rd_waddr_o;
    logic                     rd_we_o;
    logic                     illegal_o;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    idu_stage #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_valid_i    (inst_valid_i),
        .inst_ready_o    (inst_ready_o),
        .inst_i          (inst_i),
        .inst_addr_i     (inst_addr_i),
        .flush_i         (flush_i),
        .ex_load_valid_i (ex_load_valid_i),
        .ex_load_rd_i    (ex_load_rd_i),
        .rs1_raddr_o     (rs1_raddr_o),
        .rs2_raddr_o     (rs2_raddr_o),
        .rs1_rdata_i     (rs1_rdata_i),
        .rs2_rdata_i     (rs2_rdata_i),
        .stall_o         (stall_o),
        .dec_valid_o     (dec_valid_o),
        .dec_ready_i     (dec_ready_i),
        .inst_o          (inst_o),
        .dec_pc_o        (dec_pc_o),
        .dec_imm_o       (dec_imm_o),
        .rs1_rdata_o     (rs1_rdata_o),
        .rs2_rdata_o     (rs2_rdata_o),
        .dec_info_bus_o  (dec_info_bus_o),
        .rd_waddr_o      (rd_waddr_o),
        .rd_we_o         (rd_we_o),
        .illegal_o       (illegal_o)
    );

    // Register file model: x0 reads zero, other registers return a tagged address
    function automatic logic [31:0] gpr1(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : (32'hA100_0000 | {27'd0, a});
    endfunction
    function automatic logic [31:0] gpr2(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : (32'hB200_0000 | {27'd0, a});
    endfunction

    assign rs1_rdata_i = gpr1(rs1_raddr_o);
    assign rs2_rdata_i = gpr2(rs2_raddr_o);

    typedef struct {
        logic [31:0]              inst;
        logic [DECINFO_WIDTH-1:0] info;
        logic [31:0]              imm;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic                     we;
        logic                     ill;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] seq_inst[4];

    function automatic logic [DECINFO_WIDTH-1:0] mk_info(input dec_group_e grp, input int op_bit);
        logic [DECINFO_WIDTH-1:0] r;
        r = '0;
        r[2:0] = grp;
        r[op_bit] = 1'b1;
        return r;
    endfunction

    function automatic logic [DECINFO_WIDTH-1:0] bit_of(input int op_bit);
        logic [DECINFO_WIDTH-1:0] r;
        r = '0;
        r[op_bit] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] addi_x0(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    task automatic add_vec(input logic [31:0] inst, input logic [DECINFO_WIDTH-1:0] info,
                           input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic we, input logic ill);
        vec_t v;
        v.inst = inst; v.info = info; v.imm = imm; v.rs1 = rs1;
        v.rs2 = rs2; v.rd = rd; v.we = we; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic ready);
        inst_valid_i = valid;
        inst_i       = inst;
        inst_addr_i  = pc;
        dec_ready_i  = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push seq_inst in order with id_ex stalled until the stage refuses; returns accepted count
    task automatic push_until_full(input logic [31:0] base_pc, output int pushed);
        int  idx;
        logic will;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, seq_inst[(idx > 3) ? 3 : idx], base_pc + 32'(idx * 4), 1'b0);
            #1;
            will = inst_ready_o;
            step();
            if (will) idx++;
        end
        inst_valid_i = 1'b0;
        pushed = idx;
    endtask

    initial begin
        int pushed;

        rst_n = 1'b0;
        flush_i = 1'b0;
        ex_load_valid_i = 1'b0;
        ex_load_rd_i = 5'd0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);

        // Reset state
        #1;
        checkOutput("rst_dec_valid", 32'(dec_valid_o), 32'd0);
        checkOutput("rst_inst_ready", 32'(inst_ready_o), 32'd1);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_inst_o", inst_o, 32'd0);
        checkOutput("rst_info", 32'(dec_info_bus_o), 32'd0);
        checkOutput("rst_rd_we", 32'(rd_we_o), 32'd0);
        #11;
        rst_n = 1'b1;

        // Decode table
        add_vec(32'h0050_0093, mk_info(GRP_ALU, ALU_ADD) | bit_of(ALU_OP2IMM), 32'd5, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
        add_vec(32'h0001_2283, mk_info(GRP_MEM, MEM_LOAD) | bit_of(MEM_SIZE_LSB + 1), 32'd0, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0);
        add_vec(32'h0012_8333, mk_info(GRP_ALU, ALU_ADD), 32'd0, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        add_vec(32'h4041_83B3, mk_info(GRP_ALU, ALU_SUB), 32'd0, 5'd3, 5'd4, 5'd7, 1'b1, 1'b0);
        add_vec(32'h0020_8463, mk_info(GRP_BJP, BJP_BEQ), 32'd8, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        add_vec(32'h0020_A223, mk_info(GRP_MEM, MEM_STORE) | bit_of(MEM_SIZE_LSB + 1), 32'd4, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        add_vec(32'h1234_5537, mk_info(GRP_ALU, ALU_LUI), 32'h1234_5000, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
        add_vec(32'h0100_00EF, mk_info(GRP_BJP, BJP_JAL), 32'd16, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
        add_vec(32'h4033_5293, mk_info(GRP_ALU, ALU_SRA) | bit_of(ALU_OP2IMM), 32'd3, 5'd6, 5'd0, 5'd5, 1'b1, 1'b0);
        add_vec(32'h3001_10F3, mk_info(GRP_CSR, CSR_CSRRW), 32'h300, 5'd2, 5'd0, 5'd1, 1'b1, 1'b0);
        add_vec(32'h0000_0073, mk_info(GRP_SYS, SYS_ECALL), 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        add_vec(32'hFFFF_FFFF, '0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        add_vec(32'h0020_A463, '0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
`ifdef IDU_RVM_EN
        add_vec(32'h0220_81B3, mk_info(GRP_MULDIV, MD_MUL), 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
`else
        add_vec(32'h0220_81B3, '0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
`endif

        foreach (vecs[i]) begin
            logic [31:0] pc;
            pc = 32'h8000_0000 + 32'(i * 4);
            applyStimulus(1'b1, vecs[i].inst, pc, 1'b1);
            step();
            inst_valid_i = 1'b0;
            #1;
            checkOutput($sformatf("v%0d_latency", i), 32'(dec_valid_o), 32'd0);
            checkOutput($sformatf("v%0d_rs1_raddr", i), 32'(rs1_raddr_o), 32'(vecs[i].rs1));
            checkOutput($sformatf("v%0d_rs2_raddr", i), 32'(rs2_raddr_o), 32'(vecs[i].rs2));
            step();
            checkOutput($sformatf("v%0d_valid", i), 32'(dec_valid_o), 32'd1);
            checkOutput($sformatf("v%0d_inst", i), inst_o, vecs[i].inst);
            checkOutput($sformatf("v%0d_pc", i), dec_pc_o, pc);
            checkOutput($sformatf("v%0d_info", i), 32'(dec_info_bus_o), 32'(vecs[i].info));
            checkOutput($sformatf("v%0d_imm", i), dec_imm_o, vecs[i].imm);
            checkOutput($sformatf("v%0d_rd", i), 32'(rd_waddr_o), 32'(vecs[i].rd));
            checkOutput($sformatf("v%0d_rd_we", i), 32'(rd_we_o), 32'(vecs[i].we));
            checkOutput($sformatf("v%0d_illegal", i), 32'(illegal_o), 32'(vecs[i].ill));
            checkOutput($sformatf("v%0d_rs1_data", i), rs1_rdata_o, gpr1(vecs[i].rs1));
            checkOutput($sformatf("v%0d_rs2_data", i), rs2_rdata_o, gpr2(vecs[i].rs2));
            step();
            checkOutput($sformatf("v%0d_drained", i), 32'(dec_valid_o), 32'd0);
        end

        // Back-pressure: one in the output register plus DEPTH queued, then in-order release
        for (int k = 0; k < 4; k++) seq_inst[k] = addi_x0(5'(k + 1), 12'(k + 1));
        push_until_full(32'h8000_1000, pushed);
        checkOutput("bp_accepted", 32'(pushed), 32'(1 + DEPTH));
        checkOutput("bp_ready_low", 32'(inst_ready_o), 32'd0);
        checkOutput("bp_valid", 32'(dec_valid_o), 32'd1);
        checkOutput("bp_hold_first", inst_o, seq_inst[0]);
        dec_ready_i = 1'b1;
        step();
        checkOutput("bp_out1_valid", 32'(dec_valid_o), 32'd1);
        checkOutput("bp_out1", inst_o, seq_inst[1]);
        checkOutput("bp_ready_back", 32'(inst_ready_o), 32'd1);
        step();
        checkOutput("bp_out2_valid", 32'(dec_valid_o), 32'd1);
        checkOutput("bp_out2", inst_o, seq_inst[2]);
        checkOutput("bp_out2_imm", dec_imm_o, 32'd3);
        step();
        checkOutput("bp_empty", 32'(dec_valid_o), 32'd0);

        // Load-use hazard from the output register and from EX
        applyStimulus(1'b1, 32'h0001_2283, 32'h8000_2000, 1'b1);
        step();
        applyStimulus(1'b1, 32'h0012_8333, 32'h8000_2004, 1'b1);
        step();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("hz_out_only", 32'(stall_o), 32'd1);
        ex_load_valid_i = 1'b1;
        ex_load_rd_i = 5'd5;
        #1;
        checkOutput("hz_both", 32'(stall_o), 32'd1);
        step();
        checkOutput("hz_hold_lw", inst_o, 32'h0001_2283);
        checkOutput("hz_still", 32'(stall_o), 32'd1);
        dec_ready_i = 1'b1;
        step();
        checkOutput("hz_lw_gone", 32'(dec_valid_o), 32'd0);
        checkOutput("hz_ex_only", 32'(stall_o), 32'd1);
        ex_load_valid_i = 1'b0;
        #1;
        checkOutput("hz_clear", 32'(stall_o), 32'd0);
        step();
        checkOutput("hz_add_valid", 32'(dec_valid_o), 32'd1);
        checkOutput("hz_add_inst", inst_o, 32'h0012_8333);
        checkOutput("hz_add_pc", dec_pc_o, 32'h8000_2004);
        step();

        // Flush with a full queue and a push offered in the same cycle
        for (int k = 0; k < 4; k++) seq_inst[k] = addi_x0(5'(k + 11), 12'(k + 11));
        push_until_full(32'h8000_3000, pushed);
        applyStimulus(1'b1, seq_inst[3], 32'h8000_300C, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
        #1;
        checkOutput("fl_valid", 32'(dec_valid_o), 32'd0);
        checkOutput("fl_ready", 32'(inst_ready_o), 32'd1);
        checkOutput("fl_stall", 32'(stall_o), 32'd0);
        step();
        step();
        checkOutput("fl_stays_empty", 32'(dec_valid_o), 32'd0);

        // Flush beats a same-cycle push and a same-cycle advance
        applyStimulus(1'b1, addi_x0(5'd20, 12'd20), 32'h8000_4000, 1'b1);
        step();
        applyStimulus(1'b1, addi_x0(5'd21, 12'd21), 32'h8000_4004, 1'b1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        inst_valid_i = 1'b0;
        #1;
        checkOutput("fl2_valid", 32'(dec_valid_o), 32'd0);
        step();
        checkOutput("fl2_push_dropped", 32'(dec_valid_o), 32'd0);
        applyStimulus(1'b1, addi_x0(5'd22, 12'd22), 32'h8000_4008, 1'b1);
        step();
        inst_valid_i = 1'b0;
        step();
        checkOutput("fl2_next_valid", 32'(dec_valid_o), 32'd1);
        checkOutput("fl2_next_inst", inst_o, addi_x0(5'd22, 12'd22));
        step();

        // Asynchronous reset in the middle of a burst
        dec_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, addi_x0(5'(k + 25), 12'(k + 25)), 32'h8000_5000 + 32'(k * 4), 1'b0);
            step();
        end
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(dec_valid_o), 32'd0);
        checkOutput("ar_ready", 32'(inst_ready_o), 32'd1);
        checkOutput("ar_inst_o", inst_o, 32'd0);
        checkOutput("ar_stall", 32'(stall_o), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, addi_x0(5'd9, 12'd9), 32'h8000_6000, 1'b1);
        step();
        inst_valid_i = 1'b0;
        step();
        checkOutput("ar_post_valid", 32'(dec_valid_o), 32'd1);
        checkOutput("ar_post_inst", inst_o, addi_x0(5'd9, 12'd9));
        checkOutput("ar_post_rd", 32'(rd_waddr_o), 32'd9);
        checkOutput("ar_post_imm", dec_imm_o, 32'd9);
        step();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
